mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory port: the pipeline's MEM-stage load/store controller that drives MemRead/MemWrite/addr/wd into the byte-addressed little-endian data memory and consumes rd.
- Memory reads are combinational while MemRead=1; writes commit all 4 bytes at posedge when MemWrite=1.
- Adds byte/halfword loads (sign/zero extend) and byte/halfword stores via read-modify-write, range/alignment error reporting, and a busy/stall handshake back to the pipeline.

---
 rtl/mem_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: loads with sign/zero extend, sub-word stores by read-modify-write. Macro ALIGN_CHECK_EN rejects misaligned accesses.
// Latency: load and word store respond 2 cycles after accept, sub-word store 3, rejected request 1.
// Backpressure: busy stays high while an access is in flight; requests presented while busy are ignored and must be held.
module mem_access_ctrl #(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] addr,
   output logic [31:0] wd,
   input  logic [31:0] rd
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] STORE  = 3'd2;
   localparam logic [2:0] RMW_RD = 3'd3;
   localparam logic [2:0] RMW_WR = 3'd4;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;

   typedef struct packed {
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic [2:0]  state;
   req_t        req_q;
   logic [31:0] merge_buf;
   logic [31:0] merged;
   logic        range_err;
   logic        align_err;
   logic        req_err;

   // Extract the addressed lane from a full memory word and extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: res = {{24{sgn & b[7]}}, b};
         SZ_HALF: res = {{16{sgn & h[15]}}, h};
         default: res = word;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                              input logic [15:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
      logic [31:0] res;
      res = word;
      if (size == SZ_BYTE) begin
         case (lane)
            2'd0:    res[7:0]   = data[7:0];
            2'd1:    res[15:8]  = data[7:0];
            2'd2:    res[23:16] = data[7:0];
            default: res[31:24] = data[7:0];
         endcase
      end else if (lane[1]) begin
         res[31:16] = data;
      end else begin
         res[15:0] = data;
      end
      return res;
   endfunction

   assign range_err = (req_addr >= 32'(MEM_BYTES));

`ifdef ALIGN_CHECK_EN
   always_comb begin
      align_err = 1'b0;
      case (req_size)
         SZ_BYTE: align_err = 1'b0;
         SZ_HALF: align_err = req_addr[0];
         default: align_err = |req_addr[1:0];
      endcase
   end
`else
   // Without the check, the lane select below simply ignores the low bits.
   assign align_err = 1'b0;
`endif

   assign req_err = range_err | align_err;

   assign merged   = merge_lane(merge_buf, req_q.wdata[15:0], req_q.size, req_q.addr[1:0]);
   assign busy     = (state != IDLE);
   assign MemRead  = (state == LOAD)  || (state == RMW_RD);
   assign MemWrite = (state == STORE) || (state == RMW_WR);
   assign addr     = busy ? {req_q.addr[31:2], 2'b00} : 32'd0;

   always_comb begin
      wd = 32'd0;
      if (state == STORE)
         wd = req_q.wdata;
      else if (state == RMW_WR)
         wd = merged;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_q      <= '0;
         merge_buf  <= 32'd0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_q.size  <= req_size;
                  req_q.sgn   <= req_signed;
                  req_q.addr  <= req_addr;
                  req_q.wdata <= req_wdata;
                  if (req_err) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (!req_write) begin
                     state <= LOAD;
                  end else if (req_size == SZ_BYTE || req_size == SZ_HALF) begin
                     state <= RMW_RD;
                  end else begin
                     state <= STORE;
                  end
               end
            end
            LOAD: begin
               resp_rdata <= load_extend(rd, req_q.size, req_q.addr[1:0], req_q.sgn);
               resp_valid <= 1'b1;
               state      <= IDLE;
            end
            STORE: begin
               resp_valid <= 1'b1;
               state      <= IDLE;
            end
            RMW_RD: begin
               merge_buf <= rd;
               state     <= RMW_WR;
            end
            RMW_WR: begin
               resp_valid <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-addressed little-endian memory model.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        busy;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;

   logic        mem_load;
   logic [7:0]  mem [0:1023];

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   int both_cnt = 0;
   int rd0 = 0;
   int wr0 = 0;
   logic [31:0] last_rd_addr = 32'd0;
   logic [31:0] last_wr_addr = 32'd0;
   logic [31:0] last_wr_wd = 32'd0;
   logic [31:0] prev_data;

   mem_access_ctrl #(.MEM_BYTES(1024)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wd(wd), .rd(rd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
         mem[16'h10] <= 8'hBB;
         mem[16'h11] <= 8'hAA;
         mem[16'h12] <= 8'h99;
         mem[16'h13] <= 8'h88;
      end else if (MemWrite === 1'b1) begin
         mem[{addr[9:2], 2'd0}] <= wd[7:0];
         mem[{addr[9:2], 2'd1}] <= wd[15:8];
         mem[{addr[9:2], 2'd2}] <= wd[23:16];
         mem[{addr[9:2], 2'd3}] <= wd[31:24];
      end
   end

   always_comb begin
      rd = 32'd0;
      if (MemRead === 1'b1)
         rd = {mem[{addr[9:2], 2'd3}], mem[{addr[9:2], 2'd2}],
               mem[{addr[9:2], 2'd1}], mem[{addr[9:2], 2'd0}]};
   end

   always @(negedge clk) begin
      if (MemRead === 1'b1) begin
         rd_cnt++;
         last_rd_addr = addr;
      end
      if (MemWrite === 1'b1) begin
         wr_cnt++;
         last_wr_addr = addr;
         last_wr_wd   = wd;
      end
      if (MemRead === 1'b1 && MemWrite === 1'b1) both_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge: present a request for one cycle.
   task automatic start(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
      rd0        = rd_cnt;
      wr0        = wr_cnt;
      req_valid  = 1'b1;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = d;
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      #1;
      start(w, sz, sg, a, d);
   endtask

   task automatic finish_txn(input string tag, input int exp_lat, input logic exp_err,
                             input logic [31:0] exp_data, input int exp_rd, input int exp_wr);
      int lat;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      #1;
      chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, ".resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
      chk({tag, ".resp_rdata"}, resp_rdata, exp_data);
      chk({tag, ".memread_cycles"}, 32'(rd_cnt - rd0), 32'(exp_rd));
      chk({tag, ".memwrite_cycles"}, 32'(wr_cnt - wr0), 32'(exp_wr));
   endtask

   initial begin
      rst_n      = 1'b0;
      mem_load   = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset.busy", {31'd0, busy}, 32'd0);
      chk("reset.resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("reset.resp_err", {31'd0, resp_err}, 32'd0);
      chk("reset.MemRead", {31'd0, MemRead}, 32'd0);
      chk("reset.MemWrite", {31'd0, MemWrite}, 32'd0);
      chk("reset.addr", addr, 32'd0);
      chk("reset.wd", wd, 32'd0);
      chk("reset.resp_rdata", resp_rdata, 32'd0);
      rst_n    = 1'b1;
      mem_load = 1'b0;

      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
      chk("ld_w10.busy", {31'd0, busy}, 32'd1);
      chk("ld_w10.addr", addr, 32'h10);
      finish_txn("ld_w10", 2, 1'b0, 32'h8899AABB, 1, 0);
      chk("ld_w10.rd_addr", last_rd_addr, 32'h10);

      issue(1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
      finish_txn("ld_sb13", 2, 1'b0, 32'hFFFFFF88, 1, 0);
      issue(1'b0, 2'd0, 1'b0, 32'h11, 32'd0);
      finish_txn("ld_ub11", 2, 1'b0, 32'h000000AA, 1, 0);
      issue(1'b0, 2'd1, 1'b1, 32'h12, 32'd0);
      finish_txn("ld_sh12", 2, 1'b0, 32'hFFFF8899, 1, 0);

      issue(1'b1, 2'd0, 1'b0, 32'h12, 32'hDEADBE55);
      finish_txn("st_b12", 3, 1'b0, 32'hFFFF8899, 1, 1);
      chk("st_b12.wr_addr", last_wr_addr, 32'h10);
      chk("st_b12.wd", last_wr_wd, 32'h8855AABB);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
      finish_txn("ld_w10_after", 2, 1'b0, 32'h8855AABB, 1, 0);

`ifdef ALIGN_CHECK_EN
      prev_data = 32'h8855AABB;
      issue(1'b0, 2'd1, 1'b1, 32'h11, 32'd0);
      finish_txn("ld_sh11_misaligned", 1, 1'b1, prev_data, 0, 0);
`else
      prev_data = 32'hFFFFAABB;
      issue(1'b0, 2'd1, 1'b1, 32'h11, 32'd0);
      finish_txn("ld_sh11_forced", 2, 1'b0, prev_data, 1, 0);
`endif

      issue(1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
      finish_txn("ld_w400_range", 1, 1'b0 | 1'b1, prev_data, 0, 0);
      start(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
      finish_txn("ld_w10_backtoback", 2, 1'b0, 32'h8855AABB, 1, 0);

      issue(1'b1, 2'd1, 1'b0, 32'h10, 32'hCAFE1234);
      finish_txn("st_h10", 3, 1'b0, 32'h8855AABB, 1, 1);
      chk("st_h10.wd", last_wr_wd, 32'h88551234);
      issue(1'b1, 2'd2, 1'b0, 32'h14, 32'h01020304);
      finish_txn("st_w14", 2, 1'b0, 32'h8855AABB, 0, 1);
      chk("st_w14.wr_addr", last_wr_addr, 32'h14);
      chk("st_w14.wd", last_wr_wd, 32'h01020304);
      issue(1'b0, 2'd1, 1'b0, 32'h16, 32'd0);
      finish_txn("ld_uh16", 2, 1'b0, 32'h00000102, 1, 0);
      issue(1'b0, 2'd3, 1'b1, 32'h14, 32'd0);
      finish_txn("ld_size3_14", 2, 1'b0, 32'h01020304, 1, 0);
      issue(1'b0, 2'd0, 1'b1, 32'h3FF, 32'd0);
      finish_txn("ld_sb3ff_edge", 2, 1'b0, 32'h00000000, 1, 0);
      issue(1'b1, 2'd0, 1'b0, 32'h400, 32'h000000EE);
      finish_txn("st_b400_range", 1, 1'b1, 32'h00000000, 0, 0);

      // Reset lands while the byte store is in its read phase.
      issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000066);
      chk("rst_rmw.in_read", {31'd0, MemRead}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_rmw.busy", {31'd0, busy}, 32'd0);
      chk("rst_rmw.MemRead", {31'd0, MemRead}, 32'd0);
      chk("rst_rmw.MemWrite", {31'd0, MemWrite}, 32'd0);
      chk("rst_rmw.addr", addr, 32'd0);
      chk("rst_rmw.wd", wd, 32'd0);
      chk("rst_rmw.resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rmw.resp_rdata", resp_rdata, 32'd0);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_rmw.no_write", 32'(wr_cnt - wr0), 32'd0);
      chk("rst_rmw.mem11", {24'd0, mem[17]}, 32'h00000012);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
      finish_txn("ld_w10_post_reset", 2, 1'b0, 32'h88551234, 1, 0);

      chk("strobe_overlap", 32'(both_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
